button_color_ctrl: RTL and testbench



---
 rtl/btn_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 76 +++++++
 rtl/button_color_ctrl.sv | 136 +++++++++++++
 tb/tb_button_color_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton colour selector and the LED driver.
// Holds the FSM state encoding, colour codes and a colour-advance helper.
package btn_pkg;

    // Press-classification FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_e;

    // Colour selection, decoded by the LED driver
    typedef logic [1:0] color_t;

    localparam color_t COLOR_RED   = 2'd0;
    localparam color_t COLOR_GREEN = 2'd1;
    localparam color_t COLOR_BLUE  = 2'd2;
    localparam color_t COLOR_OFF   = 2'd3;

    // Next colour in the cycle; OFF wraps back to RED
    function automatic color_t color_advance(input color_t c);
        return color_t'(c + 2'd1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-flop synchroniser, polarity normalisation,
// debounce counter and registered press/release edge pulses.
//
// Ports:
//   i_clk       - system clock
//   i_rst_n     - synchronous active-low reset
//   i_btn       - raw asynchronous button pin
//   o_level     - debounced level, 1 = pressed
//   o_press     - one-cycle pulse when o_level rises
//   o_release   - one-cycle pulse when o_level falls
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Raw pin value while the button is released
    localparam logic RAW_RELEASED = BTN_ACTIVE_LOW;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [DB_W-1:0] r_cnt;
    logic            r_press;
    logic            r_release;

    logic w_pressed;
    logic w_diff;
    logic w_flip;

    assign w_pressed = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_diff    = w_pressed ^ r_level;
    // Mismatch has persisted for DEBOUNCE_CYCLES consecutive cycles
    assign w_flip    = w_diff && (r_cnt == DB_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1   <= RAW_RELEASED;
            r_sync2   <= RAW_RELEASED;
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            // Pulses register alongside the level so they line up with it
            r_press   <= w_flip & ~r_level;
            r_release <= w_flip &  r_level;
            if (w_flip) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt   <= r_cnt + DB_W'(1);
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_color_ctrl.sv
// User colour selection: short press advances colour, long press returns
// to red. Wraps the debouncer and adds the press-classification FSM.
//
// Ports:
//   pin_clk_12mhz - 12 MHz board clock
//   rst_n         - synchronous active-low reset
//   pin_btn       - raw pushbutton pin
//   btn_level     - debounced level, 1 = pressed
//   press_pulse   - debounced press edge pulse
//   release_pulse - debounced release edge pulse
//   short_press   - pulse: released before long threshold
//   long_press    - pulse: long threshold reached while held
//   color_state   - 0 red, 1 green, 2 blue, 3 off
module button_color_ctrl
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter int LONG_CYCLES     = 12_000_000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       pin_clk_12mhz,
    input  logic       rst_n,
    input  logic       pin_btn,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_press,
    output logic       long_press,
    output logic [1:0] color_state
);

    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic w_press;
    logic w_release;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debounce (
        .i_clk     (pin_clk_12mhz),
        .i_rst_n   (rst_n),
        .i_btn     (pin_btn),
        .o_level   (btn_level),
        .o_press   (w_press),
        .o_release (w_release)
    );

    assign press_pulse   = w_press;
    assign release_pulse = w_release;

    btn_state_e        r_state;
    logic [HOLD_W-1:0] r_hold;
    color_t            r_color;
    logic              r_short;
    logic              r_long;

    btn_state_e        w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    color_t            w_color_nxt;
    logic              w_short_nxt;
    logic              w_long_nxt;
    logic              w_hold_last;

    assign w_hold_last = (r_hold == HOLD_LAST);

    // State and registered outputs
    always_ff @(posedge pin_clk_12mhz) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_color <= COLOR_RED;
            r_short <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_color <= w_color_nxt;
            r_short <= w_short_nxt;
            r_long  <= w_long_nxt;
        end
    end

    // Next-state logic; release takes priority over the long threshold
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_press) w_state_nxt = PRESSED;
            end
            PRESSED: begin
                if (w_release)        w_state_nxt = IDLE;
                else if (w_hold_last) w_state_nxt = LONG_HELD;
            end
            LONG_HELD: begin
                if (w_release) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        w_hold_nxt  = r_hold;
        w_color_nxt = r_color;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_press) w_hold_nxt = '0;
            end
            PRESSED: begin
                if (w_release) begin
                    w_short_nxt = 1'b1;
                    w_color_nxt = color_advance(r_color);
                end else if (w_hold_last) begin
                    w_long_nxt  = 1'b1;
                    w_color_nxt = COLOR_RED;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold + HOLD_W'(1);
                end
            end
            LONG_HELD: begin
                w_hold_nxt = r_hold;
            end
            default: w_hold_nxt = '0;
        endcase
    end

    assign short_press = r_short;
    assign long_press  = r_long;
    assign color_state = r_color;

endmodule

// File: tb/tb_button_color_ctrl.sv
// Directed self-checking bench for button_color_ctrl with short
// thresholds (debounce 8, long 64, active-low button).
module tb_button_color_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pin_btn;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic [1:0] color_state;

    int checks;
    int failures;

    button_color_ctrl #(
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (64),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .pin_clk_12mhz (clk),
        .rst_n         (rst_n),
        .pin_btn       (pin_btn),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .color_state   (color_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Stimulus only: press, hold, release, let the event settle
    task automatic short_cycle(input int hold);
        pin_btn = 1'b0;
        ticks(10 + hold);
        pin_btn = 1'b1;
        ticks(12);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        pin_btn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, short_press,
                 long_press, color_state} !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=0", i,
                    {btn_level, press_pulse, release_pulse, short_press,
                     long_press, color_state});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, short_press,
                 long_press, color_state} !== 7'b0) begin
                failures++;
                $display("FAIL reset_after cyc=%0d got=%b exp=0", i,
                    {btn_level, press_pulse, release_pulse, short_press,
                     long_press, color_state});
            end
        end
    endtask

    task automatic test_bounce();
        int npress;
        int rise;
        logic p_at_rise;
        npress    = 0;
        rise      = 0;
        p_at_rise = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pin_btn = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (press_pulse === 1'b1) npress++;
            end
        end
        pin_btn = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (press_pulse === 1'b1) npress++;
            if (btn_level === 1'b1 && rise == 0) begin
                rise      = k;
                p_at_rise = press_pulse;
            end
        end
        checks++;
        if (rise != 10) begin
            failures++;
            $display("FAIL bounce_latency got=%0d exp=10", rise);
        end
        checks++;
        if (npress != 1 || p_at_rise !== 1'b1) begin
            failures++;
            $display("FAIL bounce_pulse count=%0d at_rise=%b exp=1/1",
                npress, p_at_rise);
        end
        ticks(10);
        pin_btn = 1'b1;
        ticks(9);
        checks++;
        if (release_pulse !== 1'b0 || btn_level !== 1'b1) begin
            failures++;
            $display("FAIL bounce_rel_early rel=%b lvl=%b exp=0/1",
                release_pulse, btn_level);
        end
        tick();
        checks++;
        if (release_pulse !== 1'b1 || btn_level !== 1'b0) begin
            failures++;
            $display("FAIL bounce_rel rel=%b lvl=%b exp=1/0",
                release_pulse, btn_level);
        end
        tick();
        checks++;
        if (short_press !== 1'b1 || long_press !== 1'b0 ||
            color_state !== 2'd1) begin
            failures++;
            $display("FAIL bounce_short s=%b l=%b col=%0d exp=1/0/1",
                short_press, long_press, color_state);
        end
        tick();
        checks++;
        if (short_press !== 1'b0) begin
            failures++;
            $display("FAIL bounce_short_len got=%b exp=0", short_press);
        end
    endtask

    task automatic test_short();
        logic [1:0] exp;
        pin_btn = 1'b1;
        rst_n   = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        checks++;
        if (color_state !== 2'd0) begin
            failures++;
            $display("FAIL short_init col=%0d exp=0", color_state);
        end
        for (int r = 0; r < 4; r++) begin
            exp     = 2'(r + 1);
            pin_btn = 1'b0;
            ticks(9);
            checks++;
            if (btn_level !== 1'b0 || press_pulse !== 1'b0) begin
                failures++;
                $display("FAIL short_early r=%0d lvl=%b p=%b exp=0/0",
                    r, btn_level, press_pulse);
            end
            tick();
            checks++;
            if (btn_level !== 1'b1 || press_pulse !== 1'b1) begin
                failures++;
                $display("FAIL short_press r=%0d lvl=%b p=%b exp=1/1",
                    r, btn_level, press_pulse);
            end
            ticks(20);
            pin_btn = 1'b1;
            ticks(10);
            checks++;
            if (release_pulse !== 1'b1 || press_pulse !== 1'b0) begin
                failures++;
                $display("FAIL short_rel r=%0d rel=%b p=%b exp=1/0",
                    r, release_pulse, press_pulse);
            end
            tick();
            checks++;
            if (short_press !== 1'b1 || long_press !== 1'b0 ||
                color_state !== exp) begin
                failures++;
                $display("FAIL short_evt r=%0d s=%b l=%b col=%0d exp=1/0/%0d",
                    r, short_press, long_press, color_state, exp);
            end
            tick();
            checks++;
            if (short_press !== 1'b0 || color_state !== exp) begin
                failures++;
                $display("FAIL short_after r=%0d s=%b col=%0d exp=0/%0d",
                    r, short_press, color_state, exp);
            end
            ticks(3);
        end
    endtask

    task automatic test_long();
        short_cycle(5);
        short_cycle(5);
        checks++;
        if (color_state !== 2'd2) begin
            failures++;
            $display("FAIL long_prep col=%0d exp=2", color_state);
        end
        pin_btn = 1'b0;
        ticks(10);
        checks++;
        if (press_pulse !== 1'b1) begin
            failures++;
            $display("FAIL long_press_pulse got=%b exp=1", press_pulse);
        end
        for (int k = 1; k <= 66; k++) begin
            tick();
            if (k == 64) begin
                checks++;
                if (long_press !== 1'b0 || color_state !== 2'd2) begin
                    failures++;
                    $display("FAIL long_early l=%b col=%0d exp=0/2",
                        long_press, color_state);
                end
            end
            if (k == 65) begin
                checks++;
                if (long_press !== 1'b1 || short_press !== 1'b0 ||
                    color_state !== 2'd0) begin
                    failures++;
                    $display("FAIL long_evt l=%b s=%b col=%0d exp=1/0/0",
                        long_press, short_press, color_state);
                end
            end
            if (k == 66) begin
                checks++;
                if (long_press !== 1'b0) begin
                    failures++;
                    $display("FAIL long_len got=%b exp=0", long_press);
                end
            end
        end
        ticks(34);
        pin_btn = 1'b1;
        ticks(10);
        checks++;
        if (release_pulse !== 1'b1) begin
            failures++;
            $display("FAIL long_rel got=%b exp=1", release_pulse);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (short_press !== 1'b0 || long_press !== 1'b0 ||
                color_state !== 2'd0) begin
                failures++;
                $display("FAIL long_norel k=%0d s=%b l=%b col=%0d exp=0/0/0",
                    k, short_press, long_press, color_state);
            end
        end
    endtask

    task automatic test_tie();
        pin_btn = 1'b0;
        ticks(10);
        checks++;
        if (press_pulse !== 1'b1 || color_state !== 2'd0) begin
            failures++;
            $display("FAIL tie_press p=%b col=%0d exp=1/0",
                press_pulse, color_state);
        end
        ticks(54);
        pin_btn = 1'b1;
        ticks(10);
        checks++;
        if (release_pulse !== 1'b1 || long_press !== 1'b0) begin
            failures++;
            $display("FAIL tie_rel rel=%b l=%b exp=1/0",
                release_pulse, long_press);
        end
        tick();
        checks++;
        if (short_press !== 1'b1 || long_press !== 1'b0 ||
            color_state !== 2'd1) begin
            failures++;
            $display("FAIL tie_evt s=%b l=%b col=%0d exp=1/0/1",
                short_press, long_press, color_state);
        end
        tick();
        checks++;
        if (short_press !== 1'b0 || long_press !== 1'b0) begin
            failures++;
            $display("FAIL tie_after s=%b l=%b exp=0/0",
                short_press, long_press);
        end
        ticks(4);
    endtask

    task automatic test_reset_mid();
        pin_btn = 1'b0;
        ticks(10);
        checks++;
        if (press_pulse !== 1'b1 || color_state !== 2'd1) begin
            failures++;
            $display("FAIL rmid_press p=%b col=%0d exp=1/1",
                press_pulse, color_state);
        end
        ticks(31);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({btn_level, press_pulse, release_pulse, short_press,
                 long_press, color_state} !== 7'b0) begin
                failures++;
                $display("FAIL rmid_reset k=%0d got=%b exp=0", k,
                    {btn_level, press_pulse, release_pulse, short_press,
                     long_press, color_state});
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 9) begin
                checks++;
                if (press_pulse !== 1'b0 || btn_level !== 1'b0) begin
                    failures++;
                    $display("FAIL rmid_early p=%b lvl=%b exp=0/0",
                        press_pulse, btn_level);
                end
            end
            if (k == 10) begin
                checks++;
                if (press_pulse !== 1'b1 || color_state !== 2'd0) begin
                    failures++;
                    $display("FAIL rmid_redetect p=%b col=%0d exp=1/0",
                        press_pulse, color_state);
                end
            end
        end
        ticks(5);
        pin_btn = 1'b1;
        ticks(10);
        checks++;
        if (release_pulse !== 1'b1) begin
            failures++;
            $display("FAIL rmid_rel got=%b exp=1", release_pulse);
        end
        tick();
        checks++;
        if (short_press !== 1'b1 || color_state !== 2'd1) begin
            failures++;
            $display("FAIL rmid_short s=%b col=%0d exp=1/1",
                short_press, color_state);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        pin_btn  = 1'b1;
        test_reset();
        test_bounce();
        test_short();
        test_long();
        test_tie();
        test_reset_mid();
        ticks(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
